spike_count_classifier: RTL
===========================

// Module: spike_count_classifier
// PURPOSE
//  N-channel output-layer spike counter for the classification CSNN.
//  Each channel counts gated rising spike edges into its potential register during one inference window.
//  At window end, a sequential argmax picks the winning class, and the result is held under a valid/ack handshake.
//  Sits after the last neuron layer and feeds the result/readout logic.
// PARAMETERS
//  N_CH    10               number of output neurons/classes (>=2)
//  CNT_W   3                potential counter width per channel
//  SAT_EN  1                1: counters saturate at 2^CNT_W-1; 0: counters wrap modulo 2^CNT_W
//  IDX_W   $clog2(N_CH)     derived; class index width
// PORTS
//  clk          in   1             system clock, rising edge
//  rst_n        in   1             asynchronous active-low reset
//  start        in   1             pulse: clear all channels, open window
//  en_u         in   1             spike gate; spikes are counted only while high
//  spike        in   N_CH          raw spike levels, bit i = neuron i
//  win_end      in   1             pulse: close window, begin classification
//  class_ack    in   1             consumer accepts the result
//  potential_u  out  N_CH*CNT_W    live counters; channel i = [i*CNT_W +: CNT_W]
//  class_valid  out  1             result valid; held until class_ack
//  class_idx    out  IDX_W         winning channel
//  class_cnt    out  CNT_W         winning channel's count
//  tie          out  1             another channel equals the max, or all counts are 0
//  busy         out  1             state != IDLE && state != DONE
// BEHAVIOUR
//  Reset: all outputs 0, all counters and sync flops 0, state IDLE. Reset is legal mid-window and mid-scan; it aborts everything.
//  FSM states: IDLE, COUNT, DRAIN1, DRAIN2, SCAN, DONE.
//   IDLE   --start-->           COUNT
//   COUNT  --win_end-->         DRAIN1
//   DRAIN1 -->                  DRAIN2
//   DRAIN2 -->                  SCAN (i=0)
//   SCAN   --i==N_CH-1-->       DONE
//   DONE   --class_ack-->       IDLE
//  start in any state: synchronously clears counters, sync flops, class_* and tie, then enters COUNT. start has priority over win_end and class_ack.
//  win_end outside COUNT: ignored. class_ack outside DONE: ignored.
//  Per channel: g = spike[i] & en_u & (state==COUNT). Sync pair s1<=g, s2<=s1.
//   Increment when s1 & !s2, in COUNT or DRAIN*.
//   Latency: g high before edge k gives a counter update at edge k+1.
//  A level held high counts once. Re-counting needs a low cycle on g (sampled).
//  Counter at max: SAT_EN=1 holds at max; SAT_EN=0 wraps to 0.
//  DRAIN1/2 let in-flight edges land, so a spike sampled on the win_end edge is NOT counted.
//  SCAN: one channel per clock.
//   Strict greater-than replaces the best; the lowest index wins ties.
//   tie=1 if any later channel equals the running max.
//   class_valid rises N_CH+2 clocks after the edge that sampled win_end.
//  DONE: class_idx, class_cnt and tie are stable; potential_u is frozen until start.
//  class_valid & class_ack: clears class_valid on the next edge, which returns to IDLE. The other result fields hold their last values.
// STRUCTURE
//  Package scc_pkg holds:
//   - state enum scc_state_t
//   - localparam CNT_MAX
//   - function sat_inc(cnt, sat_en)
//  Sub-module spike_edge_counter (one per channel, generate loop) contains the gate, sync pair, edge detect and counter. Its ports are clk, rst_n, clr, cnt_en, spike_g, cnt.
//  The top level holds the FSM, the scan index/best registers and the output registers.
// TESTING
//  1. N_CH=4, CNT_W=3. start; ch2 three 1-cycle pulses, ch0 one pulse; win_end -> idx=2, cnt=3, tie=0; valid at +6 clk.
//  2. ch1 held high 20 cycles -> potential ch1=1 (single count).
//  3. SAT_EN=1: ch3 pulsed 10x -> cnt 7. SAT_EN=0: 10x -> cnt 2.
//  4. ch1=ch3=5 -> idx=1, tie=1. No spikes at all -> idx=0, cnt=0, tie=1.
//  5. en_u=0 during pulses -> no count. Spike on the win_end cycle -> not counted.
//  6. start during SCAN, and rst_n low mid-COUNT -> counters 0, valid 0, correct restart. class_valid holds until class_ack.

Source files
------------

// File: rtl/scc_pkg.sv
// Shared types and helpers for the output-layer spike count classifier.
// Holds the controller state encoding, the default counter width and the
// counter increment helper used by every channel.
package scc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DRAIN1,
    DRAIN2,
    SCAN,
    DONE
  } scc_state_t;

  localparam int CNT_W_DEFAULT = 3;
  localparam int CNT_MAX       = (1 << CNT_W_DEFAULT) - 1;

  // Next counter value: at the ceiling either hold (saturating) or roll
  // over to zero (wrapping). The ceiling is passed in so that one helper
  // serves any counter width.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] cnt,
    input logic        sat_en,
    input logic [31:0] max = 32'(CNT_MAX)
  );
    if (cnt >= max) begin
      sat_inc = sat_en ? max : 32'd0;
    end else begin
      sat_inc = cnt + 32'd1;
    end
  endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// Per-channel gated spike edge counter: two-flop sample pair, rising-edge
// detect and a saturating or wrapping potential counter.
// Latency: gated spike high before edge k updates cnt at edge k+1.
// Backpressure: none; counting is enabled or frozen by cnt_en.
// Ports: clk, rst_n (async active-low), clr (sync clear of all state),
//        cnt_en (edges may land), spike_g (already gated spike level),
//        cnt (live potential).
module spike_edge_counter
  import scc_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             spike_g,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] MAX_VAL = (32'd1 << CNT_W) - 32'd1;

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else if (clr) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= spike_g;
      s2 <= s1;
      // A level held high produces a single s1 & !s2 cycle, so it counts once.
      if (cnt_en && s1 && !s2) begin
        cnt <= CNT_W'(sat_inc(32'(cnt), SAT_EN, MAX_VAL));
      end
    end
  end

endmodule

// File: rtl/spike_count_classifier.sv
// N-channel output-layer spike counter with sequential argmax classifier.
// Latency: class_valid rises N_CH+2 clocks after the edge that samples win_end.
// Backpressure: result is held (class_valid high, fields stable) until class_ack.
// Ports: clk, rst_n (async active-low); start opens a fresh window;
//        en_u gates spikes; spike[N_CH] raw levels; win_end closes window;
//        class_ack consumes result; potential_u live counters;
//        class_valid/class_idx/class_cnt/tie result; busy while counting/scanning.
module spike_count_classifier
  import scc_pkg::*;
#(
  parameter int N_CH   = 10,
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter bit SAT_EN = 1'b1,
  parameter int IDX_W  = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  en_u,
  input  logic [N_CH-1:0]       spike,
  input  logic                  win_end,
  input  logic                  class_ack,
  output logic [N_CH*CNT_W-1:0] potential_u,
  output logic                  class_valid,
  output logic [IDX_W-1:0]      class_idx,
  output logic [CNT_W-1:0]      class_cnt,
  output logic                  tie,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  scc_state_t       state;
  scc_state_t       state_nxt;

  logic [CNT_W-1:0] ch_cnt [N_CH];
  logic             gate_open;
  logic             cnt_en;

  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic             tie_run;
  logic [CNT_W-1:0] cur_cnt;
  logic [IDX_W-1:0] cand_idx;
  logic [CNT_W-1:0] cand_cnt;
  logic             cand_tie;
  logic             scan_last;

  // The gate also closes on the cycle that carries win_end, so a spike
  // coinciding with the window close never reaches the sample pair.
  assign gate_open = en_u & (state == COUNT) & ~win_end;
  // Counting stays enabled through both drain cycles so edges already in
  // the sample pair still land before the scan reads the counters.
  assign cnt_en    = (state == COUNT) || (state == DRAIN1) || (state == DRAIN2);
  assign busy      = (state != IDLE) && (state != DONE);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    spike_edge_counter #(
      .CNT_W  (CNT_W),
      .SAT_EN (SAT_EN)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start),
      .cnt_en  (cnt_en),
      .spike_g (spike[gi] & gate_open),
      .cnt     (ch_cnt[gi])
    );
    assign potential_u[gi*CNT_W +: CNT_W] = ch_cnt[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = COUNT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        COUNT:   if (win_end) state_nxt = DRAIN1;
        DRAIN1:  state_nxt = DRAIN2;
        DRAIN2:  state_nxt = SCAN;
        SCAN:    if (scan_last) state_nxt = DONE;
        DONE:    if (class_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cur_cnt   = ch_cnt[scan_idx];
  assign scan_last = (scan_idx == LAST_IDX);

  // One channel per clock: channel 0 seeds the running best, a strictly
  // larger count replaces it (so the lowest index keeps ties), and any
  // later equal count flags a tie.
  always_comb begin
    cand_idx = best_idx;
    cand_cnt = best_cnt;
    cand_tie = tie_run;
    if (scan_idx == '0) begin
      cand_idx = '0;
      cand_cnt = cur_cnt;
      cand_tie = 1'b0;
    end else if (cur_cnt > best_cnt) begin
      cand_idx = scan_idx;
      cand_cnt = cur_cnt;
      cand_tie = 1'b0;
    end else if (cur_cnt == best_cnt) begin
      cand_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx    <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      tie_run     <= 1'b0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_cnt   <= '0;
      tie         <= 1'b0;
    end else if (start) begin
      scan_idx    <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      tie_run     <= 1'b0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_cnt   <= '0;
      tie         <= 1'b0;
    end else begin
      case (state)
        DRAIN2: scan_idx <= '0;
        SCAN: begin
          best_idx <= cand_idx;
          best_cnt <= cand_cnt;
          tie_run  <= cand_tie;
          scan_idx <= scan_idx + IDX_W'(1);
          if (scan_last) begin
            class_valid <= 1'b1;
            class_idx   <= cand_idx;
            class_cnt   <= cand_cnt;
            // An all-zero window has no real winner; report it as a tie.
            tie         <= cand_tie | (cand_cnt == '0);
          end
        end
        DONE: if (class_ack) class_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
